// File: rtl/md_unit_if.sv
// md_unit_if: request/response bundle between the EX stage and the multiply/divide unit.
//   start  - operation request, sampled only while the unit is idle
//   op     - 5-bit ALUOp code (mul..remu)
//   a, b   - rs1 / rs2 operands
//   flush  - synchronous abort from a branch/jump redirect
//   busy   - operation in progress (pipeline stall request)
//   done   - one-cycle result-valid pulse
//   result - operation result, held until the next accepted start
// master: the pipeline side; slave: the unit.
interface md_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit for the EX stage.
// Sequence IDLE -> PREP -> RUN (XLEN cycles) -> FIX -> DONE -> IDLE, so every accepted
// operation (including divide-by-zero and signed overflow) completes with fixed latency.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract, both on operand
// magnitudes; the sign is applied in FIX.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - md_unit_if slave (start/op/a/b/flush in, busy/done/result out)
module md_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  md_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [4:0] OpMul    = 5'b10010;
  localparam logic [4:0] OpMulh   = 5'b10011;
  localparam logic [4:0] OpMulhsu = 5'b10100;
  localparam logic [4:0] OpMulhu  = 5'b10101;
  localparam logic [4:0] OpDiv    = 5'b10110;
  localparam logic [4:0] OpDivu   = 5'b10111;
  localparam logic [4:0] OpRem    = 5'b11000;
  localparam logic [4:0] OpRemu   = 5'b11001;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  // mcand: multiplicand shifted left (mul) / dividend shifted left, MSB consumed (div)
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  // mplier: multiplier shifted right (mul) / divisor, static (div)
  logic [XLEN-1:0]   mplier_q, mplier_d;
  // acc: product (mul) / {remainder, quotient} (div)
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              op_valid;
  logic              is_div, is_rem, is_divide;
  logic              signed_a, signed_b;
  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     trial, diff;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic              div_zero, overflow;
  logic [XLEN-1:0]   fix_result;

  assign op_valid = (bus.op >= OpMul) && (bus.op <= OpRemu);

  // Decode of the latched op.
  always_comb begin
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);
    is_rem    = (op_q == OpRem) || (op_q == OpRemu);
    is_divide = is_div || is_rem;
    signed_a  = (op_q == OpMul) || (op_q == OpMulh) || (op_q == OpMulhsu) ||
                (op_q == OpDiv) || (op_q == OpRem);
    signed_b  = (op_q == OpMul) || (op_q == OpMulh) || (op_q == OpDiv) || (op_q == OpRem);
    sa        = signed_a && a_q[XLEN-1];
    sb        = signed_b && b_q[XLEN-1];
    mag_a     = sa ? (~a_q + 1'b1) : a_q;
    mag_b     = sb ? (~b_q + 1'b1) : b_q;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {acc_q[2*XLEN-1:XLEN], mcand_q[XLEN-1]};
    diff     = trial - {1'b0, mplier_q};
    rem_next = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  end

  // Sign fix-up, result selection and RISC-V special-case overrides.
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    div_zero = (b_q == '0);
    overflow = (a_q == MinNeg) && (b_q == '1);
    case (op_q)
      OpMul:                     fix_result = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_result = quot_fix;
      OpRem, OpRemu:             fix_result = rem_fix;
      default:                   fix_result = '0;
    endcase
    if (is_div && div_zero) begin
      fix_result = '1;
    end else if (is_rem && div_zero) begin
      fix_result = a_q;
    end else if ((op_q == OpDiv) && overflow) begin
      fix_result = MinNeg;
    end else if ((op_q == OpRem) && overflow) begin
      fix_result = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush && op_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = is_rem ? sa : (sa ^ sb);
          state_d  = StRun;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (is_divide) begin
            acc_d   = {rem_next, acc_q[XLEN-2:0], ~diff[XLEN]};
            mcand_d = mcand_q << 1;
          end else begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_result;
          state_d  = StDone;
        end
      end
      StDone: begin
        // Flush here is too late to cancel; the pulse still goes out.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Cycle 0 is the cycle in which start is driven; outputs are sampled on the falling edge.
module tb_md_unit;

  localparam logic [4:0] OpSrl    = 5'b10000;
  localparam logic [4:0] OpMul    = 5'b10010;
  localparam logic [4:0] OpMulh   = 5'b10011;
  localparam logic [4:0] OpMulhsu = 5'b10100;
  localparam logic [4:0] OpMulhu  = 5'b10101;
  localparam logic [4:0] OpDiv    = 5'b10110;
  localparam logic [4:0] OpDivu   = 5'b10111;
  localparam logic [4:0] OpRem    = 5'b11000;
  localparam logic [4:0] OpRemu   = 5'b11001;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cycle_cnt;

  md_unit_if #(.XLEN(32)) bus ();

  md_unit #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drive start for one cycle, then scramble the operand inputs while the unit is busy.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = op ^ 5'b00001;
    bus.a     = ~a;
    bus.b     = b + 32'd3;
  endtask

  // Wait (bounded) for done; cyc=0 on timeout. busy_bad counts busy samples off their profile.
  task automatic wait_done(output int cyc, output logic [31:0] res, output int busy_bad,
                           output int t_done);
    cyc      = 0;
    res      = '0;
    busy_bad = 0;
    t_done   = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc    = c;
        res    = bus.result;
        t_done = cycle_cnt;
        if (bus.busy !== 1'b0) busy_bad++;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int cyc, output logic [31:0] res, output int busy_bad);
    int t;
    issue(op, a, b);
    wait_done(cyc, res, busy_bad, t);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    vectors++;
    if (bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int          cyc, bb;
    logic [31:0] res;
    run(OpMul, 32'd7, 32'hFFFF_FFFD, cyc, res, bb);
    vectors++;
    if (cyc !== 35) begin
      miscompares++;
      $display("FAIL mul_latency: done at cycle %0d expected 35", cyc);
    end
    vectors++;
    if (bb !== 0) begin
      miscompares++;
      $display("FAIL mul_busy_profile: %0d bad busy samples expected 0", bb);
    end
    vectors++;
    if (res !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL mul_result: got %h expected ffffffeb", res);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: got %b expected 0", bus.done);
    end
    run(OpMulh, 32'd7, 32'hFFFF_FFFD, cyc, res, bb);
    vectors++;
    if (res !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL mulh_result: got %h expected ffffffff", res);
    end
  endtask

  task automatic test_mulh_variants();
    logic [4:0]  ops [3];
    logic [31:0] exp [3];
    int          cyc, bb;
    logic [31:0] res;
    ops = '{OpMulh, OpMulhu, OpMulhsu};
    exp = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
    for (int i = 0; i < 3; i++) begin
      run(ops[i], 32'h8000_0000, 32'h8000_0000, cyc, res, bb);
      vectors++;
      if (res !== exp[i] || cyc !== 35) begin
        miscompares++;
        $display("FAIL mulh_variant_%0d: got %h at cycle %0d expected %h at 35",
                 i, res, cyc, exp[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [4:0]  ops [4];
    logic [31:0] exp [4];
    int          cyc, bb;
    logic [31:0] res;
    ops = '{OpDiv, OpRem, OpDivu, OpRemu};
    exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      run(ops[i], 32'hFFFF_FFF9, 32'd2, cyc, res, bb);
      vectors++;
      if (res !== exp[i] || cyc !== 35 || bb !== 0) begin
        miscompares++;
        $display("FAIL divide_%0d: got %h at cycle %0d (busy errs %0d) expected %h at 35",
                 i, res, cyc, bb, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [4:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    int          cyc, bb;
    logic [31:0] res;
    ops = '{OpDiv, OpRem, OpDiv, OpRem};
    as  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run(ops[i], as[i], bs[i], cyc, res, bb);
      vectors++;
      if (res !== exp[i]) begin
        miscompares++;
        $display("FAIL special_%0d_result: got %h expected %h", i, res, exp[i]);
      end
      vectors++;
      if (cyc !== 35) begin
        miscompares++;
        $display("FAIL special_%0d_latency: done at cycle %0d expected 35", i, cyc);
      end
    end
  endtask

  task automatic test_flush();
    int          cyc, bb, busy_bad, done_seen;
    logic [31:0] res;
    run(OpMul, 32'd3, 32'd5, cyc, res, bb);
    vectors++;
    if (res !== 32'd15) begin
      miscompares++;
      $display("FAIL flush_setup: got %h expected 0000000f", res);
    end
    issue(OpDivu, 32'd100, 32'd7);
    busy_bad  = 0;
    done_seen = 0;
    // Now 1 time unit into cycle 1.
    for (int c = 1; c <= 45; c++) begin
      bus.start = (c == 5);
      bus.op    = OpMul;
      bus.flush = (c == 10);
      @(negedge clk);
      if (bus.busy !== ((c <= 10) ? 1'b1 : 1'b0)) busy_bad++;
      if (bus.done !== 1'b0) done_seen++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL flush_busy: %0d bad busy samples expected 0", busy_bad);
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_done: %0d done samples expected 0", done_seen);
    end
    vectors++;
    if (bus.result !== 32'd15) begin
      miscompares++;
      $display("FAIL flush_result_hold: got %h expected 0000000f", bus.result);
    end
    run(OpDivu, 32'd100, 32'd7, cyc, res, bb);
    vectors++;
    if (res !== 32'd14 || cyc !== 35) begin
      miscompares++;
      $display("FAIL divu_after_flush: got %h at cycle %0d expected 0000000e at 35", res, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int busy_bad, done_seen;
    issue(OpMul, 32'd3, 32'd4);
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
    end
    // 1 time unit into cycle 20.
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre_busy: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: busy %b done %b result %h expected 0 0 00000000",
               bus.busy, bus.done, bus.result);
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    busy_bad  = 0;
    done_seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_bad++;
      if (bus.done !== 1'b0) done_seen++;
    end
    vectors++;
    if (busy_bad !== 0 || done_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: busy samples %0d done samples %0d expected 0 0",
               busy_bad, done_seen);
    end
  endtask

  task automatic test_non_m_op();
    int busy_bad, done_seen;
    issue(OpSrl, 32'd1, 32'd1);
    busy_bad  = 0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_bad++;
      if (bus.done !== 1'b0) done_seen++;
    end
    vectors++;
    if (busy_bad !== 0 || done_seen !== 0) begin
      miscompares++;
      $display("FAIL non_m_op_ignored: busy samples %0d done samples %0d expected 0 0",
               busy_bad, done_seen);
    end
    // start together with flush in IDLE must not be accepted.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = OpMul;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    busy_bad  = 0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_bad++;
      if (bus.done !== 1'b0) done_seen++;
    end
    vectors++;
    if (busy_bad !== 0 || done_seen !== 0) begin
      miscompares++;
      $display("FAIL idle_flush_blocks_start: busy samples %0d done samples %0d expected 0 0",
               busy_bad, done_seen);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc1, cyc2, bb, t1, t2;
    logic [31:0] res1, res2;
    issue(OpMul, 32'd3, 32'd4);
    wait_done(cyc1, res1, bb, t1);
    // Still inside the DONE cycle; issue() starts the next op in the following cycle.
    issue(OpMul, 32'd5, 32'd6);
    wait_done(cyc2, res2, bb, t2);
    vectors++;
    if (res1 !== 32'd12 || cyc1 !== 35) begin
      miscompares++;
      $display("FAIL b2b_first: got %h at cycle %0d expected 0000000c at 35", res1, cyc1);
    end
    vectors++;
    if (res2 !== 32'd30 || cyc2 !== 35) begin
      miscompares++;
      $display("FAIL b2b_second: got %h at cycle %0d expected 0000001e at 35", res2, cyc2);
    end
    vectors++;
    if ((t2 - t1) !== 36) begin
      miscompares++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart expected 36", t2 - t1);
    end
    // start raised only during the DONE cycle is ignored.
    bus.start = 1'b1;
    bus.op    = OpMul;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done_ignored: busy %b expected 0", bus.busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_mulh_variants();
    test_divide();
    test_special();
    test_flush();
    test_reset_mid();
    test_non_m_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
